// File: rtl/roundpermutation_inv_seq.sv
// Multi-step Piccolo round permutation: applies RP^-1 (or RP when ROUNDPERM_FWD_EN
// is defined and mode_fwd=1 at accept) once per clock for `count` cycles.
module roundpermutation_inv_seq #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      A,
  input  logic [CNT_W-1:0] count,
  input  logic             mode_fwd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      Q,
  output logic             busy
);

`ifdef ROUNDPERM_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t              st;
  logic [63:0]      state_q;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic [63:0]      step;

  // Byte x0 sits in [63:56]; each function lists the output bytes in order.
  function automatic logic [63:0] rp_inv(input logic [63:0] s);
    return {s[15:8], s[39:32], s[63:56], s[23:16],
            s[47:40], s[7:0], s[31:24], s[55:48]};
  endfunction

  function automatic logic [63:0] rp_fwd(input logic [63:0] s);
    return {s[47:40], s[7:0], s[31:24], s[55:48],
            s[15:8], s[39:32], s[63:56], s[23:16]};
  endfunction

  // dir is constant 0 when the forward option is compiled out, so the forward
  // path folds away and only RP^-1 remains.
  assign step = dir ? rp_fwd(state_q) : rp_inv(state_q);
  assign Q    = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st        <= IDLE;
      state_q   <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          state_q  <= A;
          cnt      <= count;
          dir      <= mode_fwd & FWD_EN;
          in_ready <= 1'b0;
          if (count != '0) begin
            st   <= RUN;
            busy <= 1'b1;
          end else begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          state_q <= step;
          cnt     <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            st        <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          st        <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          st        <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roundpermutation_inv_seq.sv
// Directed bench for roundpermutation_inv_seq: vector table plus hold/ignore/reset sequences.
module tb_roundpermutation_inv_seq;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [3:0]  count = '0;
  logic        mode_fwd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] Q;
  logic        busy;

  int errors = 0;
  int checks = 0;

  roundpermutation_inv_seq #(.CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .A(A),
    .count(count), .mode_fwd(mode_fwd), .out_valid(out_valid),
    .out_ready(out_ready), .Q(Q), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] a;
    logic [3:0]  n;
    logic        m;
    logic [63:0] q;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept one block, measure edges until out_valid, check Q and busy.
  task automatic run_block(input logic [63:0] a, input logic [3:0] n, input logic m,
                           input logic [63:0] exp, input string name);
    int lat;
    logic busy_ok;
    @(negedge CLK);
    chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
    A = a; count = n; mode_fwd = m; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; mode_fwd = 1'b0;
    lat = 0; busy_ok = 1'b1;
    @(negedge CLK);
    while (!out_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge CLK);
      lat++;
    end
    chk({name, ".latency"}, 64'(lat), 64'(n));
    chk({name, ".busy_run"}, 64'(busy_ok), 64'd1);
    chk({name, ".busy_done"}, 64'(busy), 64'd0);
    chk({name, ".q"}, Q, exp);
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    @(negedge CLK);
    chk({name, ".rel_in_ready"}, 64'(in_ready), 64'd1);
    chk({name, ".rel_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    vecs[0] = '{64'h3388552277441166, 4'd1,  1'b0, 64'h1122334455667788};
    vecs[1] = '{64'h1122334455667788, 4'd2,  1'b0, 64'h5566778811223344};
    vecs[2] = '{64'h1234567890abcdef, 4'd4,  1'b0, 64'h1234567890abcdef};
    vecs[3] = '{64'h1234567890abcdef, 4'd0,  1'b0, 64'h1234567890abcdef};
    vecs[4] = '{64'h1122334455667788, 4'd3,  1'b0, 64'h3388552277441166};
    vecs[5] = '{64'h1122334455667788, 4'd15, 1'b0, 64'h3388552277441166};
    vecs[6] = '{64'h1122334455667788, 4'd5,  1'b0, 64'h7744116633885522};
`ifdef ROUNDPERM_FWD_EN
    vecs[7] = '{64'h1122334455667788, 4'd1,  1'b1, 64'h3388552277441166};
`else
    vecs[7] = '{64'h1122334455667788, 4'd1,  1'b1, 64'h7744116633885522};
`endif

    // Reset state
    #12;
    chk("rst.q", Q, 64'h0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_block(vecs[i].a, vecs[i].n, vecs[i].m, vecs[i].q, $sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end

    // in_valid pulsed mid-RUN and in DONE must be ignored; DONE holds 5 cycles.
    @(negedge CLK);
    A = 64'h1122334455667788; count = 4'd7; in_valid = 1'b1;
    @(posedge CLK); #1; in_valid = 1'b0;
    @(negedge CLK); @(negedge CLK);
    A = 64'hdeadbeefcafef00d; count = 4'd0; in_valid = 1'b1;
    @(negedge CLK); in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge CLK);
    chk("hold.out_valid", 64'(out_valid), 64'd1);
    chk("hold.q", Q, 64'h3388552277441166);
    held = Q;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 1);
      A = 64'h0f0f0f0f0f0f0f0f;
      @(negedge CLK);
      chk($sformatf("hold%0d.out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d.q", k), Q, held);
    end
    in_valid = 1'b0;
    release_out("hold");

    // Reset mid-RUN discards the block.
    @(negedge CLK);
    A = 64'h1122334455667788; count = 4'd7; in_valid = 1'b1;
    @(posedge CLK); #1; in_valid = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("midrun.busy", 64'(busy), 64'd1);
    RST = 1'b1; #1;
    chk("midrst.q", Q, 64'h0);
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK); RST = 1'b0;
    run_block(64'h3388552277441166, 4'd1, 1'b0, 64'h1122334455667788, "postrst");
    release_out("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/roundpermutation_inv_seq.md
# roundpermutation_inv_seq

Sequential inverse round-permutation unit for the Piccolo decryption datapath. It accepts a 64-bit block and an iteration count over a valid/ready handshake, then applies the inverse Piccolo round permutation RP⁻¹ once per clock for `count` cycles. It holds the result until the consumer acknowledges it. It is the inverse-direction counterpart of the combinational `Roundpermutation` block and is used to undo round permutations when unwinding encryption rounds.

## Interface
- `CNT_W`, 4, width of the iteration-count input (max count 15)
- `CLK`  input  1  clock; all state updates on the rising edge
- `RST`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  `A` and `count` are valid
- `in_ready`  output  1  unit can accept a block (IDLE)
- `A`  input  64  input block, byte x0 = A[63:56] … x7 = A[7:0]
- `count`  input  CNT_W  number of permutation steps to apply
- `mode_fwd`  input  1  direction select; effective only with `ROUNDPERM_FWD_EN`
- `out_valid`  output  1  `Q` holds the final result
- `out_ready`  input  1  consumer accepts `Q`
- `Q`  output  64  state register contents
- `busy`  output  1  high in RUN

## Operation
- Forward RP: (x0,x1,x2,x3,x4,x5,x6,x7) → (x2,x7,x4,x1,x6,x3,x0,x5).
- Inverse RP⁻¹: (y0,y1,y2,y3,y4,y5,y6,y7) → (y6,y3,y0,y5,y2,y7,y4,y1).
- RP has order 4, so RP⁴ = identity. The unit does not reduce `count` mod 4; it performs every step literally.
- FSM states:
  - IDLE: `in_ready`=1.
    - On `in_valid`: state ← `A`, cnt ← `count`, dir ← `mode_fwd` (forced to 0 without the macro).
    - Next state is RUN if `count`≠0, else DONE.
  - RUN: each edge, state ← P(state) and cnt ← cnt−1. P is RP⁻¹ when dir=0 and RP when dir=1.
    - When cnt==1 at the edge, go to DONE.
    - Inputs are ignored in this state.
  - DONE: `out_valid`=1 and `Q` is held stable.
    - On `out_ready`: go to IDLE.
    - `out_valid` stays high until accepted. It is never dropped early.
- `in_valid` is ignored outside IDLE; `out_ready` is ignored outside DONE.
- `Q` always equals the state register. It is meaningful only while `out_valid`=1.
- Reset (asynchronous, any state, including mid-RUN): state IDLE, state register 0, cnt 0, dir 0.
  - Outputs during and after reset: `Q`=64'h0, `out_valid`=0, `busy`=0, `in_ready`=1.
  - A partially processed block is discarded and is not output.

## Timing
- Let edge k be the edge that accepts the block.
- Latency:
  - `count`=N≥1: `busy` is high for the N cycles after edge k, and `out_valid` rises after edge k+N.
  - `count`=0: `out_valid` rises after edge k, and `Q`=`A`.
- Back-to-back throughput: DONE→IDLE takes one edge, so the next accept is possible no earlier than 1 cycle after the output handshake. Maximum rate is one block per N+2 cycles.
- `in_ready` and `out_valid` are registered-state decodes, with no combinational path from `in_valid` or `out_ready`.
- If `out_ready` is held high in DONE, the block leaves DONE on the first DONE edge.

## Configuration
- `ROUNDPERM_FWD_EN` defined: `mode_fwd` is sampled at accept. A value of 1 selects forward RP steps, making the unit a multi-step forward permuter for encryption-side checks.
- Not defined: `mode_fwd` is present but ignored, and only RP⁻¹ is synthesised.

## Test plan
- Reset, then accept `A`=64'h3388552277441166 with `count`=1 → after 1 RUN cycle, `out_valid`=1 and `Q`=64'h1122334455667788. Assert `out_ready` → returns to IDLE with `in_ready`=1.
- `A`=64'h1122334455667788, `count`=2 → `Q`=64'h5566778811223344 exactly 2 cycles after accept.
- `A`=64'h1234567890abcdef, `count`=4 → `Q`=64'h1234567890abcdef. `count`=0 → same value 0 cycles after accept, with `busy` never high.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `Q` stay stable. Pulse `in_valid` with new data during RUN/DONE → it is ignored and the result is unchanged.
- Assert `RST` mid-RUN with `count`=7 → outputs go immediately to `Q`=0, `out_valid`=0, `busy`=0, `in_ready`=1. A subsequent block completes correctly.
- With `ROUNDPERM_FWD_EN`: `A`=64'h1122334455667788, `mode_fwd`=1, `count`=1 → `Q`=64'h3388552277441166. Without the macro, the same stimulus gives `Q`=64'h7744116633885522.
